// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: register offsets, CTRL/STATUS bit
// positions and the packed control-flag struct.
package timer_bank_pkg;

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_COUNT   = 2'd1,
        REG_COMPARE = 2'd2,
        REG_STATUS  = 2'd3
    } reg_sel_e;

    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_ONESHOT_BIT = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT  = 2;
    localparam int unsigned CTRL_PRESC_LSB   = 8;

    localparam int unsigned STATUS_MATCH_BIT = 0;
    localparam int unsigned STATUS_OVF_BIT   = 1;

    typedef struct packed {
        logic irq_en;
        logic oneshot;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/timer_bank_channel.sv
// One timer channel: prescaler, counter, compare register, sticky status
// bits and its interrupt contribution.
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned PRESC_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_ctrl,
    input  logic        wr_count,
    input  logic        wr_compare,
    input  logic        wr_status,
    input  logic [31:0] writedata,
    output logic [31:0] ctrl_rd,
    output logic [31:0] count_rd,
    output logic [31:0] compare_rd,
    output logic [31:0] status_rd,
    output logic        irq_req
);

    ctrl_t              ctrl_q, ctrl_d;
    logic [PRESC_W-1:0] presc_val_q, presc_val_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   compare_q, compare_d;
    logic               match_q, match_d;
    logic               ovf_q, ovf_d;
    logic               tick, match_hit, ovf_hit;

    always_comb begin
        ctrl_d      = ctrl_q;
        presc_val_d = presc_val_q;
        presc_d     = presc_q;
        count_d     = count_q;
        compare_d   = compare_q;

        tick      = ctrl_q.en && (presc_q == presc_val_q);
        match_hit = tick && (count_q == compare_q);
        ovf_hit   = tick && !match_hit && (count_q == '1);

        if (ctrl_q.en) presc_d = tick ? '0 : presc_q + 1'b1;

        // The all-ones wrap falls out of the plain increment.
        if (match_hit)  count_d = '0;
        else if (tick)  count_d = count_q + 1'b1;

        if (match_hit && ctrl_q.oneshot) ctrl_d.en = 1'b0;

        // Bus writes come last so they override same-edge hardware updates.
        if (wr_ctrl) begin
            ctrl_d.en      = writedata[CTRL_EN_BIT];
            ctrl_d.oneshot = writedata[CTRL_ONESHOT_BIT];
            ctrl_d.irq_en  = writedata[CTRL_IRQ_EN_BIT];
            presc_val_d    = writedata[CTRL_PRESC_LSB +: PRESC_W];
        end
        if (wr_count) begin
            count_d = writedata[WIDTH-1:0];
            presc_d = '0;
        end
        if (wr_compare) compare_d = writedata[WIDTH-1:0];

        match_d = (match_q && !(wr_status && writedata[STATUS_MATCH_BIT])) || match_hit;
        ovf_d   = (ovf_q && !(wr_status && writedata[STATUS_OVF_BIT])) || ovf_hit;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q      <= '0;
            presc_val_q <= '0;
            presc_q     <= '0;
            count_q     <= '0;
            compare_q   <= '0;
            match_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            presc_val_q <= presc_val_d;
            presc_q     <= presc_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            match_q     <= match_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        ctrl_rd                                 = '0;
        ctrl_rd[CTRL_EN_BIT]                    = ctrl_q.en;
        ctrl_rd[CTRL_ONESHOT_BIT]               = ctrl_q.oneshot;
        ctrl_rd[CTRL_IRQ_EN_BIT]                = ctrl_q.irq_en;
        ctrl_rd[CTRL_PRESC_LSB +: PRESC_W]      = presc_val_q;
        status_rd                               = '0;
        status_rd[STATUS_MATCH_BIT]             = match_q;
        status_rd[STATUS_OVF_BIT]               = ovf_q;
        count_rd                                = 32'(count_q);
        compare_rd                              = 32'(compare_q);
        irq_req                                 = match_q && ctrl_q.irq_en;
    end

endmodule

// File: rtl/timer_bank.sv
// Bank of NUM_CH timer channels behind a word-addressed register bus, with a
// registered read port and a registered combined interrupt.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned PRESC_W = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [$clog2(NUM_CH)+1:0]   address,
    input  logic                        read,
    input  logic                        write,
    input  logic [31:0]                 writedata,
    output logic [31:0]                 readdata,
    output logic                        readdatavalid,
    output logic                        irq
);

    localparam int unsigned AW = $clog2(NUM_CH) + 2;

    logic [AW-1:0]     ch_addr;
    reg_sel_e          reg_sel;
    logic [31:0]       ctrl_rd    [NUM_CH];
    logic [31:0]       count_rd   [NUM_CH];
    logic [31:0]       compare_rd [NUM_CH];
    logic [31:0]       status_rd  [NUM_CH];
    logic [NUM_CH-1:0] irq_req;

    logic [31:0] readdata_q, readdata_d, rd_word;
    logic        readdatavalid_q, readdatavalid_d;
    logic        irq_q, irq_d;

    assign ch_addr = address >> 2;
    assign reg_sel = reg_sel_e'(address[1:0]);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic hit;
        assign hit = write && (ch_addr == AW'(i));

        timer_channel #(
            .WIDTH   (WIDTH),
            .PRESC_W (PRESC_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .wr_ctrl    (hit && (reg_sel == REG_CTRL)),
            .wr_count   (hit && (reg_sel == REG_COUNT)),
            .wr_compare (hit && (reg_sel == REG_COMPARE)),
            .wr_status  (hit && (reg_sel == REG_STATUS)),
            .writedata  (writedata),
            .ctrl_rd    (ctrl_rd[i]),
            .count_rd   (count_rd[i]),
            .compare_rd (compare_rd[i]),
            .status_rd  (status_rd[i]),
            .irq_req    (irq_req[i])
        );
    end

    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_addr == AW'(i)) begin
                case (reg_sel)
                    REG_CTRL:    rd_word = ctrl_rd[i];
                    REG_COUNT:   rd_word = count_rd[i];
                    REG_COMPARE: rd_word = compare_rd[i];
                    REG_STATUS:  rd_word = status_rd[i];
                    default:     rd_word = '0;
                endcase
            end
        end
        readdata_d      = read ? rd_word : readdata_q;
        readdatavalid_d = read;
        irq_d           = |irq_req;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
            irq_q           <= 1'b0;
        end else begin
            readdata_q      <= readdata_d;
            readdatavalid_q <= readdatavalid_d;
            irq_q           <= irq_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = readdatavalid_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_timer_bank.sv
// Directed self-checking bench for timer_bank: a 4-channel 32-bit instance
// and a 2-channel 8-bit instance for the overflow boundary.
module tb_timer_bank;

    logic        clk = 1'b0;
    logic        reset;

    logic [3:0]  a_address;
    logic        a_read, a_write;
    logic [31:0] a_writedata, a_readdata;
    logic        a_readdatavalid, a_irq;

    logic [2:0]  b_address;
    logic        b_read, b_write;
    logic [31:0] b_writedata, b_readdata;
    logic        b_readdatavalid, b_irq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    timer_bank #(.NUM_CH(4), .WIDTH(32), .PRESC_W(8)) u_dut_a (
        .clk           (clk),
        .reset         (reset),
        .address       (a_address),
        .read          (a_read),
        .write         (a_write),
        .writedata     (a_writedata),
        .readdata      (a_readdata),
        .readdatavalid (a_readdatavalid),
        .irq           (a_irq)
    );

    timer_bank #(.NUM_CH(2), .WIDTH(8), .PRESC_W(8)) u_dut_b (
        .clk           (clk),
        .reset         (reset),
        .address       (b_address),
        .read          (b_read),
        .write         (b_write),
        .writedata     (b_writedata),
        .readdata      (b_readdata),
        .readdatavalid (b_readdatavalid),
        .irq           (b_irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input int d, input int addr, input logic [31:0] data);
        if (d == 0) begin
            a_address = addr[3:0]; a_writedata = data; a_write = 1'b1;
        end else begin
            b_address = addr[2:0]; b_writedata = data; b_write = 1'b1;
        end
        @(posedge clk); #1;
        a_write = 1'b0;
        b_write = 1'b0;
    endtask

    task automatic rd(input int d, input int addr, output logic [31:0] data);
        if (d == 0) begin
            a_address = addr[3:0]; a_read = 1'b1;
        end else begin
            b_address = addr[2:0]; b_read = 1'b1;
        end
        @(posedge clk); #1;
        a_read = 1'b0;
        b_read = 1'b0;
        check("rdv", (d == 0) ? 32'(a_readdatavalid) : 32'(b_readdatavalid), 32'd1);
        data = (d == 0) ? a_readdata : b_readdata;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] exp_ovf [3];
        exp_ovf = '{32'hFE, 32'hFF, 32'h00};

        reset = 1'b0;
        a_address = '0; a_read = 1'b0; a_write = 1'b0; a_writedata = '0;
        b_address = '0; b_read = 1'b0; b_write = 1'b0; b_writedata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check("rst_readdata", a_readdata, 32'd0);
        check("rst_rdv", 32'(a_readdatavalid), 32'd0);
        check("rst_irq", 32'(a_irq), 32'd0);

        // Channel 0: periodic match at COMPARE=4, irq follows one cycle later.
        wr(0, 2, 32'd4);
        wr(0, 0, 32'h5);
        for (int k = 1; k <= 6; k++) begin
            rd(0, 1, v);
            check("c0_count", v, (k == 6) ? 32'd0 : 32'(k - 1));
            check("c0_irq", 32'(a_irq), (k == 6) ? 32'd1 : 32'd0);
        end
        wr(0, 3, 32'd1);
        check("c0_irq_w1c_same", 32'(a_irq), 32'd1);
        @(posedge clk); #1;
        check("c0_irq_dropped", 32'(a_irq), 32'd0);
        rd(0, 3, v);
        check("c0_status_clr", v, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("c0_irq_rematch", 32'(a_irq), 32'd1);
        wr(0, 3, 32'd1);
        check("c0_irq_set_wins", 32'(a_irq), 32'd1);
        rd(0, 3, v);
        check("c0_match_set_wins", v, 32'd1);
        check("c0_irq_held", 32'(a_irq), 32'd1);
        wr(0, 0, 32'h0);
        wr(0, 3, 32'h3);

        // Channel 1: one-shot, PRESC=3, COMPARE=2.
        wr(0, 6, 32'd2);
        wr(0, 4, 32'h303);
        for (int k = 1; k <= 13; k++) begin
            rd(0, 5, v);
            check("c1_count", v, ((k - 1) >= 12) ? 32'd0 : 32'((k - 1) / 4));
        end
        rd(0, 4, v);
        check("c1_ctrl_en_cleared", v, 32'h302);
        repeat (20) @(posedge clk);
        #1;
        rd(0, 5, v);
        check("c1_count_stopped", v, 32'd0);
        rd(0, 7, v);
        check("c1_status", v, 32'd1);

        // Channel 2: COUNT write while running, PRESC=2.
        wr(0, 10, 32'd1000);
        wr(0, 8, 32'h201);
        repeat (7) @(posedge clk);
        #1;
        wr(0, 9, 32'd100);
        rd(0, 9, v);
        check("c2_count_load", v, 32'd100);
        @(posedge clk); #1;
        check("c2_rdv_pulse_end", 32'(a_readdatavalid), 32'd0);
        rd(0, 9, v);
        check("c2_count_hold", v, 32'd100);
        rd(0, 9, v);
        check("c2_count_resume", v, 32'd101);

        // Channel 3: simultaneous read and write returns pre-write data.
        wr(0, 14, 32'd7);
        a_address = 4'd14; a_writedata = 32'd9; a_write = 1'b1; a_read = 1'b1;
        @(posedge clk); #1;
        a_write = 1'b0; a_read = 1'b0;
        check("c3_rw_old", a_readdata, 32'd7);
        check("c3_rw_rdv", 32'(a_readdatavalid), 32'd1);
        rd(0, 14, v);
        check("c3_rw_new", v, 32'd9);

        // All channels running, then a one-cycle reset with a read in flight.
        wr(0, 1, 32'd0);
        wr(0, 2, 32'd3);
        wr(0, 0, 32'h5);
        wr(0, 6, 32'd9);
        wr(0, 4, 32'h1);
        wr(0, 14, 32'd20);
        wr(0, 12, 32'h5);
        repeat (10) @(posedge clk);
        #1;
        check("pre_reset_irq", 32'(a_irq), 32'd1);
        rd(0, 9, v);
        a_address = 4'd9; a_read = 1'b1; reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; a_read = 1'b0;
        check("mid_rst_readdata", a_readdata, 32'd0);
        check("mid_rst_rdv", 32'(a_readdatavalid), 32'd0);
        check("mid_rst_irq", 32'(a_irq), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        for (int a = 0; a < 16; a++) begin
            rd(0, a, v);
            check("post_rst_reg", v, 32'd0);
        end
        check("post_rst_irq", 32'(a_irq), 32'd0);

        // 8-bit instance: overflow wrap with no match.
        wr(1, 1, 32'h1FE);
        wr(1, 2, 32'h10);
        wr(1, 0, 32'h1);
        for (int k = 0; k < 3; k++) begin
            rd(1, 1, v);
            check("w8_count", v, exp_ovf[k]);
        end
        rd(1, 3, v);
        check("w8_status_ovf", v, 32'h2);
        wr(1, 3, 32'h2);
        rd(1, 3, v);
        check("w8_ovf_clr", v, 32'h0);
        wr(1, 4, 32'hFFFF_FFFF);
        rd(1, 4, v);
        check("w8_ctrl_mask", v, 32'h0000_FF07);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
